// File: rtl/cache_replacer.sv
// Victim selection and LRU/LFU/random replacement state for set-associative caches.
// One lookup/update per cycle; victim is combinational from registered state.
module cache_replacer #(
  parameter int          SET_SIZE  = 4,
  parameter int          SET_NUM   = 16,
  parameter int          CNT_WIDTH = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       en_i,
  input  logic                       inv_i,
  input  logic [1:0]                 mode_i,
  input  logic [$clog2(SET_NUM)-1:0] set_i,
  input  logic [SET_SIZE-1:0]        valid_line_i,
  input  logic [SET_SIZE-1:0]        hit_line_i,
  output logic [SET_SIZE-1:0]        out_line_o,
  output logic                       hit_o
);

  localparam int AW = $clog2(SET_SIZE);
  localparam int SW = $clog2(SET_NUM);
  localparam logic [1:0] MODE_RR  = 2'd1;
  localparam logic [1:0] MODE_LFU = 2'd2;
  localparam logic [CNT_WIDTH-1:0] CMAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CHALF = (CMAX >> 1) + CNT_WIDTH'(1);
  localparam logic [SET_SIZE-1:0]  ONE   = SET_SIZE'(1);

  logic [AW-1:0]        age  [SET_NUM][SET_SIZE];
  logic [CNT_WIDTH-1:0] freq [SET_NUM][SET_SIZE];
  logic [15:0]          lfsr;

  logic [AW-1:0]        hit_idx, inv_idx, lru_idx, lfu_idx;
  logic [AW-1:0]        vic_idx, t_idx;
  logic [CNT_WIDTH-1:0] min_f;
  logic                 all_valid, hit_any, miss;

  always_comb begin
    hit_idx = '0;
    inv_idx = '0;
    lru_idx = '0;
    for (int w = SET_SIZE - 1; w >= 0; w--) begin
      if (hit_line_i[w])
        hit_idx = AW'(w);
      if (!valid_line_i[w])
        inv_idx = AW'(w);
      if (age[set_i][w] == AW'(SET_SIZE - 1))
        lru_idx = AW'(w);
    end
    // strict compare keeps ties on the lowest index
    lfu_idx = '0;
    min_f   = freq[set_i][0];
    for (int w = 1; w < SET_SIZE; w++) begin
      if (freq[set_i][w] < min_f) begin
        min_f   = freq[set_i][w];
        lfu_idx = AW'(w);
      end
    end
  end

  always_comb begin
    all_valid = &valid_line_i;
    hit_any   = |hit_line_i;
    miss      = en_i & ~inv_i & ~hit_any;
    vic_idx   = lru_idx;
    if (!all_valid)
      vic_idx = inv_idx;
    else begin
      case (mode_i)
        MODE_RR:  vic_idx = lfsr[AW-1:0];
        MODE_LFU: vic_idx = lfu_idx;
        default:  vic_idx = lru_idx;
      endcase
    end
    t_idx      = hit_any ? hit_idx : vic_idx;
    out_line_o = miss ? (ONE << vic_idx) : '0;
    hit_o      = en_i & ~inv_i & hit_any;
  end

  logic [AW-1:0]        age_nxt  [SET_SIZE];
  logic [CNT_WIDTH-1:0] freq_nxt [SET_SIZE];
  logic [AW-1:0]        t_age;
  logic [CNT_WIDTH-1:0] t_f;
  logic                 sat;

  always_comb begin
    t_age = age[set_i][t_idx];
    t_f   = freq[set_i][t_idx];
    sat   = hit_any && (t_f == CMAX);
    for (int w = 0; w < SET_SIZE; w++) begin
      age_nxt[w]  = age[set_i][w];
      freq_nxt[w] = sat ? (freq[set_i][w] >> 1) : freq[set_i][w];
      if (AW'(w) == t_idx) begin
        age_nxt[w] = '0;
        if (!hit_any)
          freq_nxt[w] = CNT_WIDTH'(1);
        else if (sat)
          freq_nxt[w] = CHALF;
        else
          freq_nxt[w] = t_f + CNT_WIDTH'(1);
      end else if (age[set_i][w] < t_age) begin
        age_nxt[w] = age[set_i][w] + AW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr <= LFSR_SEED;
      for (int s = 0; s < SET_NUM; s++) begin
        for (int w = 0; w < SET_SIZE; w++) begin
          age[s][w]  <= AW'(w);
          freq[s][w] <= '0;
        end
      end
    end else begin
      // Galois form of x^16+x^14+x^13+x^11+1
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
      for (int s = 0; s < SET_NUM; s++) begin
        if (SW'(s) == set_i) begin
          for (int w = 0; w < SET_SIZE; w++) begin
            if (inv_i) begin
              age[s][w]  <= AW'(w);
              freq[s][w] <= '0;
            end else if (en_i) begin
              age[s][w]  <= age_nxt[w];
              freq[s][w] <= freq_nxt[w];
            end
          end
        end
      end
    end
  end

  a_hit_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    (en_i && !inv_i) |-> $onehot0(hit_line_i));

endmodule

// File: tb/tb_cache_replacer.sv
// Directed bench for cache_replacer: fill, LRU, LFU, RR, invalidate, async reset.
// Expected results go through a scoreboard queue and are checked by assertions.
module tb_cache_replacer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       inv = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [1:0] set = 2'd0;
  logic [3:0] valid = 4'h0;
  logic [3:0] hit = 4'h0;
  logic [3:0] out;
  logic       hit_w;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] out;
    logic       hit;
  } exp_t;
  exp_t sb[$];

  logic [15:0] mdl;
  logic [3:0]  rr_seq [64];
  logic [3:0]  seen;

  localparam logic [1:0] LRU = 2'd0;
  localparam logic [1:0] RR  = 2'd1;
  localparam logic [1:0] LFU = 2'd2;

  cache_replacer #(
    .SET_SIZE (4),
    .SET_NUM  (4),
    .CNT_WIDTH(4),
    .LFSR_SEED(16'hACE1)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (en),
    .inv_i       (inv),
    .mode_i      (mode),
    .set_i       (set),
    .valid_line_i(valid),
    .hit_line_i  (hit),
    .out_line_o  (out),
    .hit_o       (hit_w)
  );

  always #10 clk = ~clk;

  // reference LFSR from the polynomial definition
  always @(posedge clk or posedge rst) begin
    if (rst)
      mdl <= 16'hACE1;
    else
      mdl <= (mdl >> 1) ^ (mdl[0] ? 16'hB400 : 16'h0000);
  end

  task automatic acc(input logic e, input logic i, input logic [1:0] m,
                     input logic [1:0] s, input logic [3:0] v,
                     input logic [3:0] h);
    @(negedge clk);
    en = e;
    inv = i;
    mode = m;
    set = s;
    valid = v;
    hit = h;
  endtask

  task automatic chk(input logic [3:0] eo, input logic eh, input string tag);
    exp_t e;
    exp_t x;
    e.out = eo;
    e.hit = eh;
    sb.push_back(e);
    #1;
    x = sb.pop_front();
    checks++;
    assert (out === x.out && hit_w === x.hit) else begin
      errors++;
      $error("FAIL %s out=%b hit=%b expected out=%b hit=%b",
             tag, out, hit_w, x.out, x.hit);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0;
    inv = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    // reset state
    do_reset();
    acc(0, 0, LRU, 0, 4'hF, 4'h0); chk(4'b0000, 0, "rst_idle");
    acc(1, 0, LRU, 0, 4'hF, 4'h0); chk(4'b1000, 0, "rst_lru");

    // invalid fill
    do_reset();
    acc(1, 0, LRU, 0, 4'b0000, 4'h0); chk(4'b0001, 0, "fill_0000");
    acc(1, 0, LRU, 0, 4'b0111, 4'h0); chk(4'b1000, 0, "fill_0111");
    acc(1, 0, LFU, 0, 4'b1010, 4'h0); chk(4'b0001, 0, "fill_1010");
    acc(1, 0, LRU, 0, 4'hF, 4'b0100); chk(4'b0000, 1, "hit_flag");
    acc(0, 0, LRU, 0, 4'hF, 4'b0100); chk(4'b0000, 0, "en_low");

    // LRU on set 1
    do_reset();
    acc(1, 0, LRU, 1, 4'hF, 4'b0001); chk(4'b0000, 1, "lru_h0");
    acc(1, 0, LRU, 1, 4'hF, 4'b0010); chk(4'b0000, 1, "lru_h1");
    acc(1, 0, LRU, 1, 4'hF, 4'b0100); chk(4'b0000, 1, "lru_h2");
    acc(1, 0, LRU, 1, 4'hF, 4'b1000); chk(4'b0000, 1, "lru_h3");
    acc(1, 0, LRU, 1, 4'hF, 4'h0); chk(4'b0001, 0, "lru_m1");
    acc(1, 0, LRU, 1, 4'hF, 4'h0); chk(4'b0010, 0, "lru_m2");
    acc(1, 0, LRU, 2, 4'hF, 4'h0); chk(4'b1000, 0, "lru_set2");

    // LFU on set 0
    do_reset();
    acc(1, 0, LFU, 0, 4'hF, 4'b0010); chk(4'b0000, 1, "lfu_h1a");
    acc(1, 0, LFU, 0, 4'hF, 4'b0010); chk(4'b0000, 1, "lfu_h1b");
    acc(1, 0, LFU, 0, 4'hF, 4'b0001); chk(4'b0000, 1, "lfu_h0");
    acc(1, 0, LFU, 0, 4'hF, 4'b1000); chk(4'b0000, 1, "lfu_h3");
    acc(1, 0, LFU, 0, 4'hF, 4'h0); chk(4'b0100, 0, "lfu_min");
    for (int i = 0; i < 14; i++) begin
      acc(1, 0, LFU, 0, 4'hF, 4'b0010); chk(4'b0000, 1, "lfu_sat_hit");
    end
    acc(1, 0, LFU, 0, 4'hF, 4'h0); chk(4'b0001, 0, "lfu_after_sat");
    acc(1, 0, LFU, 0, 4'hF, 4'h0); chk(4'b0100, 0, "lfu_tie_low");

    // RR on set 3, twice from reset
    do_reset();
    seen = 4'h0;
    for (int i = 0; i < 64; i++) begin
      acc(1, 0, RR, 3, 4'hF, 4'h0);
      chk(4'b0001 << mdl[1:0], 0, "rr_model");
      rr_seq[i] = out;
      seen = seen | out;
      checks++;
      assert ($onehot(out)) else begin
        errors++;
        $error("FAIL rr_onehot out=%b expected one-hot", out);
      end
    end
    checks++;
    assert (seen === 4'hF) else begin
      errors++;
      $error("FAIL rr_cover seen=%b expected 1111", seen);
    end
    do_reset();
    for (int i = 0; i < 64; i++) begin
      acc(1, 0, RR, 3, 4'hF, 4'h0);
      chk(rr_seq[i], 0, "rr_repeat");
    end

    // invalidate set 2, with set 3 as a bystander
    do_reset();
    acc(1, 0, LRU, 3, 4'hF, 4'b1000); chk(4'b0000, 1, "inv_s3_hit");
    acc(1, 0, LRU, 2, 4'hF, 4'b1000); chk(4'b0000, 1, "inv_s2_h3");
    acc(1, 0, LRU, 2, 4'hF, 4'b0001); chk(4'b0000, 1, "inv_s2_h0");
    acc(1, 0, LRU, 2, 4'hF, 4'h0); chk(4'b0100, 0, "inv_scrambled");
    acc(1, 1, LRU, 2, 4'hF, 4'b1000); chk(4'b0000, 0, "inv_hit_mask");
    acc(1, 0, LRU, 2, 4'hF, 4'h0); chk(4'b1000, 0, "inv_lru");
    acc(1, 0, 2'd3, 3, 4'hF, 4'h0); chk(4'b0100, 0, "inv_s3_kept");

    // async reset pulsed between edges
    do_reset();
    acc(1, 0, LRU, 0, 4'hF, 4'b1000); chk(4'b0000, 1, "ar_h3");
    acc(1, 0, LRU, 0, 4'hF, 4'b0001); chk(4'b0000, 1, "ar_h0");
    acc(1, 0, LRU, 0, 4'hF, 4'h0); chk(4'b0100, 0, "ar_pre_lru");
    mode = LFU; chk(4'b0010, 0, "ar_pre_lfu");
    mode = LRU;
    rst = 1'b1;
    #1;
    rst = 1'b0;
    chk(4'b1000, 0, "ar_lru");
    mode = LFU; chk(4'b0001, 0, "ar_lfu");
    mode = RR; chk(4'b0010, 0, "ar_lfsr");
    en = 1'b0;
    acc(1, 0, LRU, 0, 4'hF, 4'h0); chk(4'b1000, 0, "ar_next");

    acc(0, 0, LRU, 0, 4'h0, 4'h0);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_replacer.md
Name: cache_replacer

Overview:
Multi-set, parametrised victim-selection and replacement-state unit for the set-associative caches. It keeps per-set LRU age and LFU frequency state, plus one global LFSR for random replacement. It returns a one-hot victim way in the same cycle as a miss, and updates the state on every access. It sits beside the tag array and is used by the I-cache and D-cache controllers.

Parameters:
SET_SIZE, 4, ways per set; power of 2, at least 2.
SET_NUM, 16, number of sets; power of 2.
CNT_WIDTH, 4, LFU counter width in bits; at least 2.
LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
en_i  in  1  access strobe; one lookup/update per cycle
inv_i  in  1  clear replacement state of set set_i
mode_i  in  2  `LRU / `RR / `LFU (replace_controller.svh encodings); reserved value behaves as `LRU
set_i  in  $clog2(SET_NUM)  set index of access or invalidate
valid_line_i  in  SET_SIZE  valid bits of the addressed set
hit_line_i  in  SET_SIZE  one-hot hit vector; zero means miss
out_line_o  out  SET_SIZE  one-hot victim way; zero when no miss
hit_o  out  1  OR of hit_line_i, qualified by en_i

Behaviour:
- Let AW = $clog2(SET_SIZE). Per set s and way w the unit holds:
  - age[s][w], AW bits; 0 = MRU, SET_SIZE-1 = LRU. Ages within a set always form a permutation.
  - freq[s][w], CNT_WIDTH bits.
- LFSR: one 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1. Advances on every clock edge while not in reset.
- Async reset (rst_i high), effective immediately, regardless of clock:
  - age[s][w] = w, so way SET_SIZE-1 is LRU.
  - freq = 0.
  - lfsr = LFSR_SEED.
  - Reset asserted mid-access discards that access's update.
- Victim selection is combinational from registered state and inputs; zero latency. Condition: en_i=1, hit_line_i=0, inv_i=0.
  - Any valid bit 0: victim = lowest-index invalid way, in all modes.
  - All valid, LRU: the way with age == SET_SIZE-1.
  - All valid, RR: way lfsr[AW-1:0].
  - All valid, LFU: the way with minimum freq; ties go to the lowest index.
  - Otherwise out_line_o = 0.
  - out_line_o is always zero or exactly one-hot.
- Multiple bits set in hit_line_i is illegal. The lowest-index hit bit is used; this is covered by a simulation assertion.
- Update on posedge clk_i when en_i=1 and inv_i=0:
  - Touched way t = hit way on a hit, victim way on a miss.
  - Only set set_i changes; all other sets hold.
  - Age: age[t] <= 0; every way with age < old age[t] increments by 1; others hold. Done in all modes, so a mode switch needs no state fix-up.
  - Freq on a miss: freq[t] <= 1 (new line); other ways in the set hold.
  - Freq on a hit, freq[t] < 2^CNT_WIDTH-1: freq[t] increments.
  - Freq on a hit, freq[t] saturated: every way in the set shifts right by 1, then freq[t] = (2^CNT_WIDTH-1 >> 1) + 1.
  - Freq is maintained in all modes.
- Invalidate, inv_i=1 on an edge:
  - set_i age and freq return to their reset values.
  - Takes priority over en_i; a same-cycle access is ignored.
  - out_line_o = 0 and hit_o = 0 while inv_i=1.
- mode_i may change between any two accesses. The selection policy changes on the next lookup; no state is flushed.
- en_i=0: no state change except the LFSR advance; outputs zero.

Test Plan:
1. Invalid fill, SET_SIZE=4, SET_NUM=4: reset, set 0, miss, valid 0000 -> out_line_o=0001. Miss with valid 0111 -> 1000. Miss with valid 1010 -> 0001.
2. LRU, set 1 all valid: hits on ways 0,1,2,3 in order, then miss -> 0001. Accept that fill, then miss -> 0010. Set 2 untouched, miss -> 1000.
3. LFU, CNT_WIDTH=4, set 0 all valid from reset: hits on way1 x2, way0 x1, way3 x1, then miss -> 0100. Then hit way1 to freq 15 and once more -> freq way1=8, way0=0, way3=0, way2=0 (the fill had set way2=1).
4. RR: 64 consecutive all-valid misses to set 3 -> every way chosen at least once and out_line_o always one-hot. Reset and repeat -> identical victim sequence.
5. Invalidate: scramble set 2 with LRU hits, then pulse inv_i on set 2 with en_i=1 -> next all-valid LRU miss gives 1000. Set 3 state unchanged. The colliding access left no trace.
6. Async reset: pulse rst_i between clock edges during a stream -> age, freq and lfsr are at reset values before the next edge. A miss in the following cycle -> 1000 (LRU).
